fp16_mul_arbiter: RTL and testbench

- Shares one pipelined FP16 (1/5/10) multiplier between N_REQ requesters, e.g. the twiddle-multiply lanes of the 16-point FFT butterflies.
- Arbitrates round-robin and issues at most one operation per cycle.
- Unpacks operands, applies the mantissa/exponent multiply core, and returns the packed result tagged with the requester ID after a fixed latency.

---
 rtl/fp16_mul_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_fp16_mul_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp16_mul_arbiter
// Purpose  : Round-robin shares one pipelined FP16 multiplier between N_REQ
//            requesters; results return tagged with the requester ID.
// Options  : define FP16_MUL_ARB_PERF_EN to add perf_busy/perf_stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module fp16_mul_arbiter #(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 2,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [16*N_REQ-1:0]   req_a,
    input  logic [16*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  resp_valid,
    output logic [ID_W-1:0]       resp_id,
    output logic [15:0]           resp_data,
    output logic                  resp_ovf,
    output logic                  ovf_sticky,
    input  logic                  ovf_clr
`ifdef FP16_MUL_ARB_PERF_EN
    ,
    output logic [15:0]           perf_busy,
    output logic [15:0]           perf_stall
`endif
);

    localparam logic [15:0] C_QNAN = 16'h7E00;
    localparam logic [14:0] C_INF  = 15'h7C00;

    logic [ID_W-1:0] r_ptr;
    logic            w_grant;
    logic [ID_W-1:0] w_gidx;

    // ------------------------------------------------------------------
    // Round-robin arbiter: first valid requester at or above the pointer
    // ------------------------------------------------------------------
    always_comb begin
        w_grant = 1'b0;
        w_gidx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_grant && req_valid[(int'(r_ptr) + k) % N_REQ]) begin
                w_grant = 1'b1;
                w_gidx  = ID_W'((int'(r_ptr) + k) % N_REQ);
            end
        end
        if (!en || !rst_n) begin
            w_grant = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready[w_gidx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= ID_W'((int'(w_gidx) + 1) % N_REQ);
        end
    end

    // ------------------------------------------------------------------
    // Multiply core on the granted operands
    // ------------------------------------------------------------------
    logic [15:0]       w_a, w_b;
    logic              w_sign, w_norm, w_guard, w_sticky, w_carry;
    logic [4:0]        w_ea, w_eb;
    logic [21:0]       w_prod;
    logic [9:0]        w_frac;
    logic [10:0]       w_rnd;
    logic signed [6:0] w_exp;
    logic              w_a_zero, w_b_zero;
    logic [15:0]       w_res;
    logic              w_res_ovf;

    assign w_a = req_a[16*w_gidx +: 16];
    assign w_b = req_b[16*w_gidx +: 16];

    always_comb begin
        w_sign   = w_a[15] ^ w_b[15];
        w_ea     = w_a[14:10];
        w_eb     = w_b[14:10];
        w_a_zero = (w_ea == 5'd0) && (w_a[9:0] == 10'd0);
        w_b_zero = (w_eb == 5'd0) && (w_b[9:0] == 10'd0);
        w_prod   = {1'b1, w_a[9:0]} * {1'b1, w_b[9:0]};
        w_norm   = w_prod[21];
        if (w_norm) begin
            w_frac   = w_prod[20:11];
            w_guard  = w_prod[10];
            w_sticky = |w_prod[9:0];
        end else begin
            w_frac   = w_prod[19:10];
            w_guard  = w_prod[9];
            w_sticky = |w_prod[8:0];
        end
        // Ties truncate: only strictly-above-half rounds up.
        w_rnd   = {1'b0, w_frac} + {10'd0, w_guard & w_sticky};
        w_carry = w_rnd[10];
        w_exp   = {2'b00, w_ea} + {2'b00, w_eb} - 7'd15 + {6'd0, w_norm} + {6'd0, w_carry};

        w_res_ovf = 1'b0;
        if (w_ea == 5'h1F || w_eb == 5'h1F) begin
            if ((w_ea == 5'h1F && w_b_zero) || (w_eb == 5'h1F && w_a_zero)) begin
                w_res = C_QNAN;
            end else begin
                w_res = {w_sign, C_INF};
            end
        end else if (w_ea == 5'd0 || w_eb == 5'd0) begin
            w_res = {w_sign, 15'd0};
        end else if (w_exp <= 7'sd0) begin
            w_res = {w_sign, 15'd0};
        end else if (w_exp > 7'sd30) begin
            w_res     = {w_sign, C_INF};
            w_res_ovf = 1'b1;
        end else begin
            // On a rounding carry w_rnd[9:0] is already zero.
            w_res = {w_sign, w_exp[4:0], w_rnd[9:0]};
        end
    end

    // ------------------------------------------------------------------
    // Result pipeline; payload only moves with a valid so outputs hold
    // ------------------------------------------------------------------
    logic            r_pv  [MUL_LAT];
    logic [ID_W-1:0] r_pid [MUL_LAT];
    logic [15:0]     r_pd  [MUL_LAT];
    logic            r_po  [MUL_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                r_pv[i]  <= 1'b0;
                r_pid[i] <= '0;
                r_pd[i]  <= '0;
                r_po[i]  <= 1'b0;
            end
        end else begin
            r_pv[0] <= w_grant;
            if (w_grant) begin
                r_pid[0] <= w_gidx;
                r_pd[0]  <= w_res;
                r_po[0]  <= w_res_ovf;
            end
            for (int i = 1; i < MUL_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                if (r_pv[i-1]) begin
                    r_pid[i] <= r_pid[i-1];
                    r_pd[i]  <= r_pd[i-1];
                    r_po[i]  <= r_po[i-1];
                end
            end
        end
    end

    assign resp_valid = r_pv[MUL_LAT-1];
    assign resp_id    = r_pid[MUL_LAT-1];
    assign resp_data  = r_pd[MUL_LAT-1];
    assign resp_ovf   = r_po[MUL_LAT-1];

    // Set has priority over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (resp_valid && resp_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

`ifdef FP16_MUL_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else if (ovf_clr) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else begin
            if (w_grant && perf_busy != 16'hFFFF) begin
                perf_busy <= perf_busy + 16'd1;
            end
            if ((|req_valid) && !w_grant && perf_stall != 16'hFFFF) begin
                perf_stall <= perf_stall + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp16_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp16_mul_arbiter
// Purpose  : Randomized and directed self-checking bench for fp16_mul_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp16_mul_arbiter;

    localparam int N_REQ   = 4;
    localparam int MUL_LAT = 2;
    localparam int ID_W    = 2;

    logic                clk;
    logic                rst_n;
    logic                en;
    logic [N_REQ-1:0]    req_valid;
    logic [16*N_REQ-1:0] req_a;
    logic [16*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]    req_ready;
    logic                resp_valid;
    logic [ID_W-1:0]     resp_id;
    logic [15:0]         resp_data;
    logic                resp_ovf;
    logic                ovf_sticky;
    logic                ovf_clr;

    fp16_mul_arbiter #(.N_REQ(N_REQ), .MUL_LAT(MUL_LAT), .ID_W(ID_W)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_ovf   (resp_ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          id;
        logic [16:0] res;
    } exp_t;

    exp_t        r_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          m_ptr    = 0;
    logic        m_sticky = 1'b0;
    logic [15:0] m_last_data = '0;
    int          m_last_id   = 0;
    logic        m_last_ovf  = 1'b0;
    logic        pend [N_REQ];
    logic [15:0] opa  [N_REQ];
    logic [15:0] opb  [N_REQ];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    // Reference multiply: exact integer product scaled to 11 significant bits.
    function automatic logic [16:0] fp_ref(input logic [15:0] a, input logic [15:0] b);
        int   ea, eb, fa, fb, m, sh, q, rem, e;
        logic s;
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        fa = int'(a[9:0]);   fb = int'(b[9:0]);
        s  = a[15] ^ b[15];
        if (ea == 31 || eb == 31) begin
            if ((ea == 31 && eb == 0 && fb == 0) || (eb == 31 && ea == 0 && fa == 0))
                return {1'b0, 16'h7E00};
            return {1'b0, s, 15'h7C00};
        end
        if (ea == 0 || eb == 0) return {1'b0, s, 15'h0};
        m   = (1024 + fa) * (1024 + fb);
        sh  = (m >= (1 << 21)) ? 11 : 10;
        q   = m >> sh;
        rem = m - (q << sh);
        if (rem > (1 << (sh - 1))) q++;
        e = ea + eb - 15 + (sh - 10);
        if (q == 2048) begin q = 1024; e++; end
        if (e <= 0) return {1'b0, s, 15'h0};
        if (e > 30) return {1'b1, s, 15'h7C00};
        return {1'b0, s, e[4:0], q[9:0]};
    endfunction

    function automatic logic [15:0] rand_op();
        int          mode;
        logic [15:0] v;
        mode = $urandom_range(0, 9);
        v    = 16'($urandom);
        case (mode)
            0: begin
                case ($urandom_range(0, 5))
                    0: v = 16'h0000;
                    1: v = 16'h8000;
                    2: v = 16'h7C00;
                    3: v = 16'hFC00;
                    4: v = 16'h0001;
                    default: v = 16'h7E00;
                endcase
            end
            1, 2: v[14:10] = 5'($urandom_range(24, 30));
            3:    v[14:10] = 5'($urandom_range(1, 8));
            default: v[14:10] = 5'($urandom_range(1, 30));
        endcase
        return v;
    endfunction

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        pend[i] = 1'b1; opa[i] = a; opb[i] = b;
    endtask

    // Checks outputs at the falling edge, then advances the model one edge.
    task automatic step();
        int   g;
        logic exp_v;
        exp_t f;
        @(negedge clk);
        if (!rst_n) begin
            r_q.delete(); m_ptr = 0; m_sticky = 1'b0;
            m_last_data = '0; m_last_id = 0; m_last_ovf = 1'b0;
        end
        g = -1;
        if (rst_n && en) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % N_REQ]) g = (m_ptr + k) % N_REQ;
            end
        end
        check("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        exp_v = (r_q.size() > 0) && (r_q[0].due == cyc);
        check("resp_valid", 32'(resp_valid), 32'(exp_v));
        if (exp_v) begin
            f = r_q.pop_front();
            m_last_data = f.res[15:0]; m_last_id = f.id; m_last_ovf = f.res[16];
        end
        check("resp_data", 32'(resp_data), 32'(m_last_data));
        check("resp_id", 32'(resp_id), 32'(m_last_id));
        check("resp_ovf", 32'(resp_ovf), 32'(m_last_ovf));
        check("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
        if (rst_n) begin
            if (exp_v && f.res[16]) m_sticky = 1'b1;
            else if (ovf_clr)       m_sticky = 1'b0;
            if (g >= 0) begin
                r_q.push_back('{due: cyc + MUL_LAT, id: g, res: fp_ref(opa[g], opb[g])});
                m_ptr   = (g + 1) % N_REQ;
                pend[g] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n, input int fill_pct);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!pend[i] && int'($urandom_range(0, 99)) < fill_pct)
                    set_op(i, rand_op(), rand_op());
                req_valid[i]        = pend[i];
                req_a[16*i +: 16]   = opa[i];
                req_b[16*i +: 16]   = opb[i];
            end
            step();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;
        run(2, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; ovf_clr = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0;
        for (int i = 0; i < N_REQ; i++) begin pend[i] = 1'b0; opa[i] = '0; opb[i] = '0; end
        #1;
        do_reset();

        // Basic products
        set_op(0, 16'h3C00, 16'h4000);
        run(4, 0);
        set_op(1, 16'h3E00, 16'h3E00);
        set_op(2, 16'hBC00, 16'h3C00);
        run(5, 0);

        // Round robin from a fresh pointer, all requesters saturated
        do_reset();
        run(8, 100);
        run(5, 0);

        // Overflow, sticky clear, and set-versus-clear in one cycle
        set_op(3, 16'h7800, 16'h4000);
        run(4, 0);
        ovf_clr = 1'b1; run(1, 0);
        ovf_clr = 1'b0; run(1, 0);
        set_op(0, 16'h7800, 16'h4000);
        run(2, 0);
        ovf_clr = 1'b1; run(1, 0);
        ovf_clr = 1'b0; run(3, 0);

        // Special operands
        set_op(1, 16'h0000, 16'h5000);
        set_op(2, 16'h7C00, 16'h0000);
        set_op(3, 16'h0400, 16'h0400);
        run(6, 0);

        // Reset while two ops are in flight
        set_op(0, rand_op(), rand_op());
        set_op(1, rand_op(), rand_op());
        run(2, 0);
        rst_n = 1'b0; run(2, 0);
        rst_n = 1'b1; run(4, 0);
        run(3, 100);
        run(5, 0);

        // Issue disabled while an earlier op drains
        set_op(2, rand_op(), rand_op());
        run(1, 0);
        en = 1'b0;
        set_op(0, rand_op(), rand_op());
        set_op(3, rand_op(), rand_op());
        run(4, 0);
        en = 1'b1;
        run(4, 0);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            en      = ($urandom_range(0, 9) != 0);
            ovf_clr = ($urandom_range(0, 19) == 0);
            run(1, 40);
        end
        en = 1'b1; ovf_clr = 1'b0;
        run(10, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
